// File: rtl/keypad_pkg.sv
// Shared types and decode helpers for the keypad entry controller.
package keypad_pkg;

  typedef enum logic [2:0] {
    IDLE,
    DEBOUNCE,
    COMMIT,
    HOLD,
    RELEASE
  } entry_state_t;

  // Indexed by {row,col}, row 0 = R0 and col 0 = C0.
  localparam logic [15:0][3:0] HEX_TAB = {
    4'hD, 4'hF, 4'h0, 4'hE,
    4'hC, 4'h9, 4'h8, 4'h7,
    4'hB, 4'h6, 4'h5, 4'h4,
    4'hA, 4'h3, 4'h2, 4'h1
  };

  function automatic logic col_onehot(input logic [3:0] c);
    return (c != 4'd0) && ((c & (c - 4'd1)) == 4'd0);
  endfunction

endpackage

// File: rtl/keypad_decode.sv
// Combinational {row,col} snapshot to hex digit; valid only for a one-hot column.
module keypad_decode
  import keypad_pkg::*;
(
  input  logic [3:0] row,   // {R0,R1,R2,R3}
  input  logic [3:0] col,   // {C0,C1,C2,C3}
  output logic [3:0] hex,
  output logic       valid
);

  logic [1:0] ri, ci;

  always_comb begin
    ri = 2'd3;
    if      (row[3]) ri = 2'd0;
    else if (row[2]) ri = 2'd1;
    else if (row[1]) ri = 2'd2;
    ci = 2'd3;
    if      (col[3]) ci = 2'd0;
    else if (col[2]) ci = 2'd1;
    else if (col[1]) ci = 2'd2;
  end

  assign hex   = HEX_TAB[{ri, ci}];
  assign valid = col_onehot(col);

endmodule

// File: rtl/keypad_entry_ctrl.sv
// Scan pacing, debounce/commit FSM and two-digit history for a 4x4 keypad.
module keypad_entry_ctrl
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV       = 48000,
  parameter int DEBOUNCE_TICKS = 20,
  parameter int RELEASE_TICKS  = 20
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] keypad_val,
  input  logic       en,
  input  logic       button_on,
  output logic       scan_tick,
  output logic       key_valid,
  output logic [3:0] digit_new,
  output logic [3:0] digit_old,
  output logic       busy
);

  localparam int DW   = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam int MAXT = (DEBOUNCE_TICKS > RELEASE_TICKS) ? DEBOUNCE_TICKS : RELEASE_TICKS;
  localparam int CW   = $clog2(MAXT + 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] DEB_C    = CW'(DEBOUNCE_TICKS);
  localparam logic [CW-1:0] REL_C    = CW'(RELEASE_TICKS);
  localparam logic [CW-1:0] ONE      = CW'(1);

  entry_state_t   state, state_d;
  logic [DW-1:0]  div;
  logic [CW-1:0]  cnt, cnt_d, cnt_inc;
  logic [7:0]     cand, cand_d, kv, dec_in;
  logic [3:0]     col_s1, col_s2, dec_hex;
  logic           btn_s1, btn_s2, dec_valid;

  assign scan_tick = (div == DIV_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) div <= '0;
    else        div <= scan_tick ? '0 : div + 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      col_s1 <= '0; col_s2 <= '0;
      btn_s1 <= 1'b0; btn_s2 <= 1'b0;
    end else begin
      col_s1 <= keypad_val[3:0]; col_s2 <= col_s1;
      btn_s1 <= button_on;       btn_s2 <= btn_s1;
    end
  end

  assign kv      = {keypad_val[7:4], col_s2};
  assign cnt_inc = (cnt == '1) ? cnt : cnt + 1'b1;

  // One decoder serves both jobs: validity of the live snapshot while idle,
  // and the hex value of the held candidate at commit time.
  assign dec_in = (state == IDLE) ? kv : cand;

  keypad_decode u_dec (
    .row   (dec_in[7:4]),
    .col   (dec_in[3:0]),
    .hex   (dec_hex),
    .valid (dec_valid)
  );

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    cand_d  = cand;
    case (state)
      IDLE: if (scan_tick && en && dec_valid) begin
        cand_d  = kv;
        cnt_d   = ONE;
        state_d = DEBOUNCE;
      end
      DEBOUNCE: if (scan_tick) begin
        if (btn_s2 && kv == cand) begin
          cnt_d = cnt_inc;
          if (cnt_inc >= DEB_C) state_d = COMMIT;
        end else begin
          state_d = IDLE;
        end
      end
      COMMIT: state_d = HOLD;
      HOLD: if (scan_tick && !btn_s2) begin
        cnt_d   = ONE;
        state_d = RELEASE;
      end
      RELEASE: if (scan_tick) begin
        if (btn_s2) begin
          state_d = HOLD;
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc >= REL_C) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
      cand  <= '0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      cand  <= cand_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      digit_new <= 4'h0;
      digit_old <= 4'h0;
    end else if (state == COMMIT) begin
      digit_old <= digit_new;
      digit_new <= dec_hex;
    end
  end

  assign key_valid = (state == COMMIT);
  assign busy      = (state != IDLE);

endmodule
